// File: rtl/expr_cmp_pkg.sv
// Shared types and defaults for the expression-DUT signature compactor.
package expr_cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int          Y_W_DEF  = 90;
    localparam logic [31:0] POLY_DEF = 32'h04C11DB7;
    localparam logic [31:0] SEED_DEF = 32'hFFFFFFFF;

    // Fold the 90-bit result bus to one 32-bit word; the top 26 bits are zero-extended.
    function automatic logic [31:0] fold32(input logic [Y_W_DEF-1:0] y);
        return y[31:0] ^ y[63:32] ^ {6'b0, y[89:64]};
    endfunction

endpackage

// File: rtl/expr_misr32.sv
// 32-bit multiple-input signature register: shift left with polynomial feedback,
// then XOR in the folded input word.
module expr_misr32
    import expr_cmp_pkg::*;
#(
    parameter logic [31:0] POLY      = POLY_DEF,
    parameter logic [31:0] RESET_VAL = SEED_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] seed,
    input  logic        en,
    input  logic [31:0] din,
    output logic [31:0] q
);

    // Signature register: load wins over a compaction step.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
        if (reset) begin
            q <= RESET_VAL;
        end else if (load) begin
            q <= seed;
        end else if (en) begin
            q <= {q[30:0], 1'b0} ^ (q[31] ? POLY : 32'h0) ^ din;
        end
    end

endmodule

// File: rtl/expr_sig_compactor.sv
// Response compactor: accepts packed DUT results on a valid/ready handshake and
// folds a programmed number of beats into a 32-bit MISR signature.
module expr_sig_compactor
    import expr_cmp_pkg::*;
#(
    parameter int          Y_W   = Y_W_DEF,
    parameter int          SIG_W = 32,
    parameter logic [31:0] POLY  = POLY_DEF,
    parameter logic [31:0] SEED  = SEED_DEF,
    parameter int          CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] vec_total,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [Y_W-1:0]   in_y,
    output logic             busy,
    output logic             done,
    output logic [SIG_W-1:0] signature,
    output logic [CNT_W-1:0] vec_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] tgt;
    logic             beat;

    // A beat is only taken in RUN; a start in the same cycle drops it.
    assign beat = (state == RUN) && in_valid && !start;

    // Next-state and handshake/status decode; start overrides every transition.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: ;
            RUN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid && (vec_cnt == tgt - CNT_ONE)) begin
                    state_nxt = DONE;
                end
            end
            DONE: done = 1'b1;
            default: state_nxt = IDLE;
        endcase
        if (start) begin
            state_nxt = RUN;
        end
    end

    // State, beat counter and target count; target is captured on start with 0 treated as 1.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: only control registers are reset here; the signature seed comes from the MISR's own reset value.
        if (reset) begin
            state   <= IDLE;
            vec_cnt <= '0;
            tgt     <= CNT_ONE;
        end else begin
            state <= state_nxt;
            if (start) begin
                vec_cnt <= '0;
                tgt     <= (vec_total == '0) ? CNT_ONE : vec_total;
            end else if (beat) begin
                vec_cnt <= vec_cnt + CNT_ONE;
            end
        end
    end

    expr_misr32 #(
        .POLY      (POLY),
        .RESET_VAL (SEED)
    ) u_misr (
        .clk   (clk),
        .reset (reset),
        .load  (start),
        .seed  (SEED),
        .en    (beat),
        .din   (fold32(in_y)),
        .q     (signature)
    );

endmodule
